// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART transceiver.
//   clk, rst_n        - system clock, asynchronous active-low reset
//   loopback          - 1: RX fed from internal TX line, tx pin held high
//   tx_data/tx_valid  - word to send, accepted when tx_ready is high
//   tx_ready, tx_done - transmitter idle / one-cycle end-of-frame pulse
//   tx                - serial output (idle high)
//   rx                - asynchronous serial input
//   rx_data/rx_valid  - one-deep holding register, released by rx_ready
//   rx_parity_err, rx_frame_err - status of the held word
//   rx_overrun        - one-cycle pulse when a completed frame is dropped
module uart_core_param #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY != 0);
  localparam logic ODD     = (PARITY == 2);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_core_param: illegal parameters (CLKS_PER_BIT=%0d)", CLKS_PER_BIT);
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  tx_state_t            tx_state, tx_state_n;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS:0]   tx_shreg, tx_shreg_n;  // parity rides above the data bits
  logic                 tx_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shreg <= tx_shreg_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shreg_n = tx_shreg;
    tx_line    = 1'b1;
    tx_done    = 1'b0;
    if (tx_state != TX_IDLE)
      tx_cnt_n = (tx_cnt == CNT_LAST) ? '0 : tx_cnt + CNT_W'(1);
    case (tx_state)
      TX_IDLE: if (tx_valid) begin
        tx_state_n = TX_START;
        tx_cnt_n   = '0;
        tx_shreg_n = {(^tx_data) ^ ODD, tx_data};
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_cnt == CNT_LAST) begin
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line = tx_shreg[0];
        if (tx_cnt == CNT_LAST) begin
          tx_shreg_n = {1'b1, tx_shreg[DATA_BITS:1]};
          tx_bit_n   = tx_bit + 4'd1;
          if (tx_bit == DATA_LAST) begin
            tx_bit_n   = '0;
            tx_state_n = HAS_PAR ? TX_PAR : TX_STOP;
          end
        end
      end
      TX_PAR: begin
        tx_line = tx_shreg[0];
        if (tx_cnt == CNT_LAST) tx_state_n = TX_STOP;
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_bit_n = tx_bit + 4'd1;
          if (tx_bit == STOP_LAST) begin
            tx_done    = 1'b1;
            tx_bit_n   = '0;
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx       = loopback | tx_line;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  rx_state_t              rx_state, rx_state_n;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_n;
  logic [3:0]             rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0]   rx_shreg, rx_shreg_n;
  logic                   rx_perr, rx_perr_n, rx_ferr, rx_ferr_n;
  logic                   rx_cmpl, rx_cmpl_n;
  logic [1:0]             rx_sync;
  logic                   rx_prev, rx_s;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= '1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_cmpl  <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], loopback ? tx_line : rx};
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shreg <= rx_shreg_n;
      rx_perr  <= rx_perr_n;
      rx_ferr  <= rx_ferr_n;
      rx_cmpl  <= rx_cmpl_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shreg_n = rx_shreg;
    rx_perr_n  = rx_perr;
    rx_ferr_n  = rx_ferr;
    rx_cmpl_n  = 1'b0;
    if (rx_state != RX_IDLE)
      rx_cnt_n = (rx_cnt == CNT_LAST) ? '0 : rx_cnt + CNT_W'(1);
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
        rx_perr_n  = 1'b0;
        rx_ferr_n  = 1'b0;
      end
      // Half-bit check re-centres the counter so later samples land mid-bit.
      RX_START: if (rx_cnt == CNT_HALF) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == CNT_LAST) begin
        rx_shreg_n = {rx_s, rx_shreg[DATA_BITS-1:1]};
        rx_bit_n   = rx_bit + 4'd1;
        if (rx_bit == DATA_LAST) begin
          rx_bit_n   = '0;
          rx_state_n = HAS_PAR ? RX_PAR : RX_STOP;
        end
      end
      RX_PAR: if (rx_cnt == CNT_LAST) begin
        rx_perr_n  = rx_s ^ (^rx_shreg) ^ ODD;
        rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_cnt == CNT_LAST) begin
        rx_ferr_n = rx_ferr | ~rx_s;
        rx_bit_n  = rx_bit + 4'd1;
        if (rx_bit == STOP_LAST) begin
          rx_bit_n   = '0;
          rx_cmpl_n  = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Holding register: a same-cycle handshake frees the slot for the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (rx_cmpl) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shreg;
          rx_parity_err <= rx_perr & HAS_PAR;
          rx_frame_err  <= rx_ferr;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_core_param.sv
module tb_uart_core_param;
  localparam int CPB = 100;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       loopback_a, tx_valid_a, tx_ready_a, tx_a, tx_done_a, rx_a;
  logic       rx_valid_a, rx_ready_a, rx_perr_a, rx_ferr_a, rx_ovr_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic       loopback_b, tx_valid_b, tx_ready_b, tx_b, tx_done_b, rx_b;
  logic       rx_valid_b, rx_ready_b, rx_perr_b, rx_ferr_b, rx_ovr_b;
  logic [6:0] tx_data_b, rx_data_b;

  uart_core_param #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .loopback(loopback_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx(tx_a), .tx_done(tx_done_a),
    .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .rx_overrun(rx_ovr_a));

  uart_core_param #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .loopback(loopback_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx(tx_b), .tx_done(tx_done_b),
    .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b), .rx_overrun(rx_ovr_b));

  int   vectors = 0;
  int   errors  = 0;
  int   ovr_cnt [2];
  int   done_cnt[2];
  exp_t q_a[$];
  exp_t q_b[$];
  logic pv_a, pr_a, pv_b, pr_b;
  int   lowc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int inst);    return inst == 0 ? tx_a : tx_b; endfunction
  function automatic logic get_ready(input int inst); return inst == 0 ? tx_ready_a : tx_ready_b; endfunction
  function automatic logic get_done(input int inst);  return inst == 0 ? tx_done_a : tx_done_b; endfunction
  function automatic logic get_rxv(input int inst);   return inst == 0 ? rx_valid_a : rx_valid_b; endfunction
  function automatic int   qsize(input int inst);     return inst == 0 ? q_a.size() : q_b.size(); endfunction

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic set_mode(input int inst, input logic lb, input logic rdy);
    if (inst == 0) begin loopback_a = lb; rx_ready_a = rdy; end
    else begin loopback_b = lb; rx_ready_b = rdy; end
  endtask

  task automatic push_exp(input int inst, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    if (inst == 0) q_a.push_back(e); else q_b.push_back(e);
  endtask

  // Monitor side of the scoreboard: compares every newly presented RX word.
  task automatic present(input int inst, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    check($sformatf("rx%0d_word_expected", inst), qsize(inst) != 0, 1);
    if (qsize(inst) != 0) begin
      if (inst == 0) e = q_a.pop_front(); else e = q_b.pop_front();
      check($sformatf("rx%0d_data", inst), d, e.data);
      check($sformatf("rx%0d_parity_err", inst), pe, e.perr);
      check($sformatf("rx%0d_frame_err", inst), fe, e.ferr);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv_a = 1'b0; pv_b = 1'b0;
      end else begin
        if (rx_valid_a && !(pv_a && !pr_a)) present(0, {1'b0, rx_data_a}, rx_perr_a, rx_ferr_a);
        if (rx_valid_b && !(pv_b && !pr_b)) present(1, {2'b0, rx_data_b}, rx_perr_b, rx_ferr_b);
        if (rx_ovr_a) ovr_cnt[0]++;
        if (rx_ovr_b) ovr_cnt[1]++;
        if (tx_done_a) done_cnt[0]++;
        if (tx_done_b) done_cnt[1]++;
        pv_a = rx_valid_a; pr_a = rx_ready_a;
        pv_b = rx_valid_b; pr_b = rx_ready_b;
      end
    end
  endtask

  // Waits (bounded) for tx_ready, raises tx_valid for one edge, then scrambles tx_data.
  task automatic send_tx(input int inst, input logic [8:0] d);
    int n = 0;
    @(negedge clk);
    while (!get_ready(inst) && n < 5000) begin @(negedge clk); n++; end
    if (!get_ready(inst)) check($sformatf("tx%0d_ready_timeout", inst), get_ready(inst), 1);
    if (inst == 0) begin tx_data_a = d[7:0]; tx_valid_a = 1'b1; end
    else begin tx_data_b = d[6:0]; tx_valid_b = 1'b1; end
    @(posedge clk); #1;
    if (inst == 0) begin tx_valid_a = 1'b0; tx_data_a = ~d[7:0]; end
    else begin tx_valid_b = 1'b0; tx_data_b = ~d[6:0]; end
  endtask

  task automatic check_tx(input int inst, input logic [8:0] d, input logic [10:0] f);
    int bad, rdy_bad = 0, done_n = 0, done_at = -1;
    send_tx(inst, d);
    for (int i = 0; i < 11; i++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (get_tx(inst) !== f[i]) bad++;
        if (get_ready(inst) !== 1'b0) rdy_bad++;
        if (get_done(inst) === 1'b1) begin done_n++; done_at = i * CPB + c; end
      end
      check($sformatf("tx%0d_bit%0d_bad_cycles", inst, i), bad, 0);
    end
    check($sformatf("tx%0d_ready_high_cycles", inst), rdy_bad, 0);
    check($sformatf("tx%0d_done_pulses", inst), done_n, 1);
    check($sformatf("tx%0d_done_cycle", inst), done_at, 1099);
    @(negedge clk);
    check($sformatf("tx%0d_ready_after", inst), get_ready(inst), 1);
    check($sformatf("tx%0d_done_after", inst), get_done(inst), 0);
  endtask

  task automatic drive_frame(input int inst, input logic [10:0] f);
    for (int i = 0; i < 11; i++) begin
      set_rx(inst, f[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
    set_rx(inst, 1'b1);
  endtask

  task automatic drain(input int inst, input int budget);
    int n = 0;
    while (qsize(inst) != 0 && n < budget) begin @(negedge clk); n++; end
    check($sformatf("rx%0d_queue_drained", inst), qsize(inst), 0);
  endtask

  task automatic reset_midframe(input int inst, input logic [8:0] txd, input logic [8:0] lbd);
    int d0, vcnt;
    set_mode(inst, 1'b0, 1'b1);
    send_tx(inst, txd);
    set_rx(inst, 1'b0); repeat (CPB) @(posedge clk); #1;
    set_rx(inst, 1'b1); repeat (CPB) @(posedge clk); #1;
    set_rx(inst, 1'b0); repeat (CPB) @(posedge clk); #1;
    set_rx(inst, 1'b1); repeat (CPB / 2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check($sformatf("rst%0d_tx", inst), get_tx(inst), 1);
    check($sformatf("rst%0d_tx_ready", inst), get_ready(inst), 1);
    check($sformatf("rst%0d_tx_done", inst), get_done(inst), 0);
    check($sformatf("rst%0d_rx_valid", inst), get_rxv(inst), 0);
    d0 = done_cnt[inst];
    repeat (3) @(posedge clk);
    set_rx(inst, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    lowc = 0; vcnt = 0;
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      if (get_tx(inst) !== 1'b1) lowc++;
      if (get_rxv(inst) !== 1'b0) vcnt++;
    end
    check($sformatf("rst%0d_tx_low_after", inst), lowc, 0);
    check($sformatf("rst%0d_no_done", inst), done_cnt[inst] - d0, 0);
    check($sformatf("rst%0d_no_rx_valid", inst), vcnt, 0);
    set_mode(inst, 1'b1, 1'b1);
    push_exp(inst, lbd, 1'b0, 1'b0);
    send_tx(inst, lbd);
    drain(inst, 3000);
    set_mode(inst, 1'b0, 1'b1);
  endtask

  initial begin
    int ov0, vcnt;
    rst_n = 1'b0;
    loopback_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = '0; rx_a = 1'b1; rx_ready_a = 1'b1;
    loopback_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = '0; rx_b = 1'b1; rx_ready_b = 1'b1;
    pv_a = 1'b0; pr_a = 1'b0; pv_b = 1'b0; pr_b = 1'b0;
    ovr_cnt = '{0, 0}; done_cnt = '{0, 0};
    fork monitor(); join_none

    #23;
    check("reset_tx_a", tx_a, 1);
    check("reset_tx_ready_a", tx_ready_a, 1);
    check("reset_tx_done_a", tx_done_a, 0);
    check("reset_rx_valid_a", rx_valid_a, 0);
    check("reset_rx_data_a", rx_data_a, 0);
    check("reset_perr_a", rx_perr_a, 0);
    check("reset_ferr_a", rx_ferr_a, 0);
    check("reset_overrun_a", rx_ovr_a, 0);
    check("reset_tx_b", tx_b, 1);
    check("reset_tx_ready_b", tx_ready_b, 1);
    check("reset_rx_valid_b", rx_valid_b, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // 0xA5, even parity 0: start, 1,0,1,0,0,1,0,1, parity 0, stop
    check_tx(0, 9'h0A5, {1'b1, 1'b0, 8'hA5, 1'b0});
    // 7'h41 (two ones), odd parity 1, two stop bits
    check_tx(1, 9'h041, {2'b11, 1'b1, 7'h41, 1'b0});

    // loopback, back-to-back words, tx pin held high
    set_mode(0, 1'b1, 1'b1);
    push_exp(0, 9'h03C, 1'b0, 1'b0);
    push_exp(0, 9'h0C3, 1'b0, 1'b0);
    lowc = 0;
    fork
      begin send_tx(0, 9'h03C); send_tx(0, 9'h0C3); end
      for (int c = 0; c < 2400; c++) begin @(negedge clk); if (tx_a !== 1'b1) lowc++; end
    join
    check("loopback_tx_pin_low_cycles", lowc, 0);
    drain(0, 2000);
    set_mode(0, 1'b0, 1'b1);
    repeat (20) @(posedge clk); #1;

    // odd parity: 7'h55 (four ones) needs parity 1; first frame sends 0, second has stop1 low
    set_mode(1, 1'b0, 1'b1);
    push_exp(1, 9'h055, 1'b1, 1'b0);
    drive_frame(1, {2'b11, 1'b0, 7'h55, 1'b0});
    push_exp(1, 9'h055, 1'b0, 1'b1);
    drive_frame(1, {2'b10, 1'b1, 7'h55, 1'b0});
    drain(1, 500);

    // overrun: hold rx_ready low across two frames
    set_mode(0, 1'b0, 1'b0);
    ov0 = ovr_cnt[0];
    push_exp(0, 9'h011, 1'b0, 1'b0);
    drive_frame(0, {1'b1, 1'b0, 8'h11, 1'b0});
    drive_frame(0, {1'b1, 1'b0, 8'h22, 1'b0});
    repeat (20) @(posedge clk); #1;
    check("overrun_pulses", ovr_cnt[0] - ov0, 1);
    check("overrun_held_data", rx_data_a, 8'h11);
    check("overrun_held_valid", rx_valid_a, 1);
    @(posedge clk); #1 rx_ready_a = 1'b1;
    @(negedge clk);
    check("overrun_valid_during_hs", rx_valid_a, 1);
    @(negedge clk);
    check("overrun_valid_after_hs", rx_valid_a, 0);

    // 30-cycle glitch is rejected, then a clean 0x7E frame (six ones, parity 0)
    vcnt = 0;
    rx_a = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 29) rx_a = 1'b1;
      if (rx_valid_a !== 1'b0) vcnt++;
    end
    check("glitch_no_rx_valid", vcnt, 0);
    @(posedge clk); #1;
    push_exp(0, 9'h07E, 1'b0, 1'b0);
    drive_frame(0, {1'b1, 1'b0, 8'h7E, 1'b0});
    drain(0, 500);

    reset_midframe(0, 9'h05A, 9'h081);
    reset_midframe(1, 9'h02A, 9'h02B);

    repeat (50) @(posedge clk);
    check("final_queue_a", q_a.size(), 0);
    check("final_queue_b", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
